mem_rd_arb_n: RTL and testbench

- Parametrised N-master AXI4 read-channel arbiter; muxes AR/R of N requesters (IFU, LSU, DMA, debug, ...) onto one memory read port.
- Sits between core-side read masters and the RAM/crossbar slave.
- Transaction-locked: grant held from AR handshake until the last R beat.
- Selectable fixed-priority or round-robin policy; explicit address/data phases; grant/busy status outputs.

---
 rtl/mem_rd_arb_n_pkg.sv | 28 ++
 rtl/mem_rd_arb_n_rr_pick.sv | 36 +++
 rtl/mem_rd_arb_n.sv | 147 ++++++++++++++
 tb/tb_mem_rd_arb_n.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_arb_n_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared types and constants for the N-master AXI4 read arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_ADDR = 3'b010,
        ST_DATA = 3'b100
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mem_rd_arb_n_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick_n
// Purpose : Combinational N-way priority picker; search starts at base, wraps.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick_n #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [IDX_W-1:0] base,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int w_slot;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        w_slot = 0;
        for (int i = 0; i < N; i++) begin
            w_slot = (int'(base) + i) % N;
            if (!valid && req[w_slot]) begin
                valid          = 1'b1;
                onehot[w_slot] = 1'b1;
                idx            = w_slot[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_rd_arb_n.sv
`default_nettype none
// ============================================================================
// Module  : mem_rd_arb_n
// Purpose : Transaction-locked N-master AXI4 read arbiter (fixed / round-robin).
// Revision: 1.0 - initial release
// ============================================================================
module mem_rd_arb_n
    import mem_arb_pkg::*;
#(
    parameter int N_MST    = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ID_W     = 4,
    parameter int ARB_MODE = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_MST-1:0]         m_arvalid,
    output logic [N_MST-1:0]         m_arready,
    input  logic [N_MST*ADDR_W-1:0]  m_araddr,
    input  logic [N_MST*ID_W-1:0]    m_arid,
    input  logic [N_MST*8-1:0]       m_arlen,
    input  logic [N_MST*3-1:0]       m_arsize,
    input  logic [N_MST*2-1:0]       m_arburst,
    output logic [N_MST-1:0]         m_rvalid,
    input  logic [N_MST-1:0]         m_rready,
    output logic [N_MST*DATA_W-1:0]  m_rdata,
    output logic [N_MST*2-1:0]       m_rresp,
    output logic [N_MST-1:0]         m_rlast,
    output logic [N_MST*ID_W-1:0]    m_rid,
    output logic                     s_arvalid,
    output logic [ADDR_W-1:0]        s_araddr,
    output logic [ID_W-1:0]          s_arid,
    output logic [7:0]               s_arlen,
    output logic [2:0]               s_arsize,
    output logic [1:0]               s_arburst,
    input  logic                     s_arready,
    input  logic                     s_rvalid,
    input  logic [DATA_W-1:0]        s_rdata,
    input  logic [1:0]               s_rresp,
    input  logic                     s_rlast,
    input  logic [ID_W-1:0]          s_rid,
    output logic                     s_rready,
    output logic [N_MST-1:0]         grant,
    output logic                     busy
);

    localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;

    arb_state_t       r_state, w_state_nxt;
    logic [N_MST-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0] r_gidx, w_gidx_nxt;
    logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0] w_base, w_pick_idx;
    logic [N_MST-1:0] w_pick_oh;
    logic             w_pick_valid;
    logic             w_in_addr, w_in_data, w_r_done;

    // Fixed priority is simply the rotating picker pinned at index 0.
    assign w_base = (ARB_MODE == ARB_RR) ? r_rr_ptr : '0;

    rr_pick_n #(
        .N     (N_MST),
        .IDX_W (IDX_W)
    ) u_pick (
        .base   (w_base),
        .req    (m_arvalid),
        .onehot (w_pick_oh),
        .idx    (w_pick_idx),
        .valid  (w_pick_valid)
    );

    assign w_in_addr = (r_state == ST_ADDR);
    assign w_in_data = (r_state == ST_DATA);
    assign w_r_done  = w_in_data & s_rvalid & s_rready & s_rlast;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_gidx_nxt   = r_gidx;
        w_rr_ptr_nxt = r_rr_ptr;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_ADDR;
                    w_grant_nxt = w_pick_oh;
                    w_gidx_nxt  = w_pick_idx;
                end
            end
            ST_ADDR: begin
                if (s_arvalid && s_arready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_r_done) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = (r_gidx == IDX_W'(N_MST-1)) ? '0 : r_gidx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Downstream side: only the owner's fields are forwarded, zero otherwise.
    assign s_arvalid = w_in_addr & m_arvalid[r_gidx];
    assign s_araddr  = w_in_addr ? m_araddr [r_gidx*ADDR_W +: ADDR_W] : '0;
    assign s_arid    = w_in_addr ? m_arid   [r_gidx*ID_W   +: ID_W]   : '0;
    assign s_arlen   = w_in_addr ? m_arlen  [r_gidx*8      +: 8]      : '0;
    assign s_arsize  = w_in_addr ? m_arsize [r_gidx*3      +: 3]      : '0;
    assign s_arburst = w_in_addr ? m_arburst[r_gidx*2      +: 2]      : '0;
    assign s_rready  = w_in_data & m_rready[r_gidx];

    for (genvar i = 0; i < N_MST; i++) begin : g_mst
        logic w_own_r;
        assign w_own_r      = w_in_data & r_grant[i];
        assign m_arready[i] = w_in_addr & r_grant[i] & s_arready;
        assign m_rvalid[i]  = w_own_r & s_rvalid;
        assign m_rlast[i]   = w_own_r & s_rlast;
        assign m_rdata[i*DATA_W +: DATA_W] = w_own_r ? s_rdata : '0;
        assign m_rresp[i*2 +: 2]           = w_own_r ? s_rresp : '0;
        assign m_rid[i*ID_W +: ID_W]       = w_own_r ? s_rid   : '0;
    end

    assign grant = r_grant;
    assign busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_arb_n.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_rd_arb_n
// Purpose : Self-checking bench: 4-master round-robin and 2-master fixed DUTs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_rd_arb_n;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ptr    = 0;

    // 4-master round-robin instance
    logic [3:0]   arv, arr, rv, rrdy, rl, grant;
    logic [127:0] araddr, rdata;
    logic [15:0]  arid, rid;
    logic [31:0]  arlen;
    logic [11:0]  arsize;
    logic [7:0]   arburst, rresp;
    logic         s_arvalid, s_arready, s_rvalid, s_rlast, s_rready, busy;
    logic [31:0]  s_araddr, s_rdata;
    logic [3:0]   s_arid, s_rid;
    logic [7:0]   s_arlen;
    logic [2:0]   s_arsize;
    logic [1:0]   s_arburst, s_rresp;

    // 2-master fixed-priority instance
    logic [1:0]   f_arv, f_arr, f_rv, f_rrdy, f_rl, f_grant;
    logic [63:0]  f_araddr, f_rdata;
    logic [7:0]   f_arid, f_rid;
    logic [15:0]  f_arlen;
    logic [5:0]   f_arsize;
    logic [3:0]   f_arburst, f_rresp;
    logic         f_s_arvalid, f_s_arready, f_s_rvalid, f_s_rlast, f_s_rready, f_busy;
    logic [31:0]  f_s_araddr, f_s_rdata;
    logic [3:0]   f_s_arid, f_s_rid;
    logic [7:0]   f_s_arlen;
    logic [2:0]   f_s_arsize;
    logic [1:0]   f_s_arburst, f_s_rresp;

    mem_rd_arb_n #(.N_MST(4), .ADDR_W(32), .DATA_W(32), .ID_W(4), .ARB_MODE(ARB_RR)) dut_rr (
        .clock(clk), .reset(reset),
        .m_arvalid(arv), .m_arready(arr), .m_araddr(araddr), .m_arid(arid),
        .m_arlen(arlen), .m_arsize(arsize), .m_arburst(arburst),
        .m_rvalid(rv), .m_rready(rrdy), .m_rdata(rdata), .m_rresp(rresp),
        .m_rlast(rl), .m_rid(rid),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rid(s_rid), .s_rready(s_rready), .grant(grant), .busy(busy)
    );

    mem_rd_arb_n #(.N_MST(2), .ADDR_W(32), .DATA_W(32), .ID_W(4), .ARB_MODE(ARB_FIXED)) dut_fx (
        .clock(clk), .reset(reset),
        .m_arvalid(f_arv), .m_arready(f_arr), .m_araddr(f_araddr), .m_arid(f_arid),
        .m_arlen(f_arlen), .m_arsize(f_arsize), .m_arburst(f_arburst),
        .m_rvalid(f_rv), .m_rready(f_rrdy), .m_rdata(f_rdata), .m_rresp(f_rresp),
        .m_rlast(f_rl), .m_rid(f_rid),
        .s_arvalid(f_s_arvalid), .s_araddr(f_s_araddr), .s_arid(f_s_arid), .s_arlen(f_s_arlen),
        .s_arsize(f_s_arsize), .s_arburst(f_s_arburst), .s_arready(f_s_arready),
        .s_rvalid(f_s_rvalid), .s_rdata(f_s_rdata), .s_rresp(f_s_rresp), .s_rlast(f_s_rlast),
        .s_rid(f_s_rid), .s_rready(f_s_rready), .grant(f_grant), .busy(f_busy)
    );

    // Reference policy: first requester found scanning upward from the pointer.
    function automatic int model_pick(input logic [3:0] req, input int p);
        for (int k = 0; k < 4; k++) begin
            if (req[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic set_fields(input int m, input logic [31:0] addr, input logic [7:0] len);
        araddr[m*32 +: 32] = addr;
        arid[m*4 +: 4]     = 4'($urandom);
        arlen[m*8 +: 8]    = len;
        arsize[m*3 +: 3]   = 3'($urandom_range(0, 2));
        arburst[m*2 +: 2]  = AXI_BURST_INCR;
    endtask

    // One complete RR transaction, entered and left at a negedge in IDLE.
    task automatic rr_serve(input bit toggle, input bit keep, input logic [3:0] late,
                            input int abort_after);
        int w, nb, beat, cyc;
        bit hs;
        logic [31:0]  d;
        logic [1:0]   rs;
        logic [3:0]   id, ev, e_l;
        logic [127:0] e_rd;
        logic [7:0]   e_rr;
        logic [15:0]  e_id;
        w = model_pick(arv, ptr);
        if (w < 0) begin
            errors++;
            $display("FAIL rr_setup: no pending request, arv=%b", arv);
            return;
        end
        ev = 4'(1 << w);
        nb = int'(arlen[w*8 +: 8]) + 1;
        #1;
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || s_arvalid !== 1'b0)
            begin errors++; $display("FAIL rr_idle: grant=%b busy=%b s_arvalid=%b, want 0000/0/0", grant, busy, s_arvalid); end
        @(negedge clk); #1;
        checks++;
        if (grant !== ev || busy !== 1'b1 || s_arvalid !== 1'b1 ||
            {s_araddr, s_arid, s_arlen, s_arsize, s_arburst} !==
            {araddr[w*32 +: 32], arid[w*4 +: 4], arlen[w*8 +: 8], arsize[w*3 +: 3], arburst[w*2 +: 2]})
            begin errors++; $display("FAIL rr_addr: grant=%b busy=%b arvalid=%b addr=%h len=%h, want grant=%b addr=%h len=%h",
                                     grant, busy, s_arvalid, s_araddr, s_arlen, ev, araddr[w*32 +: 32], arlen[w*8 +: 8]); end
        if ($urandom_range(0, 1) == 1) begin
            @(negedge clk); #1;
            checks++;
            if (grant !== ev || s_arvalid !== 1'b1 || arr !== 4'b0)
                begin errors++; $display("FAIL rr_addr_hold: grant=%b s_arvalid=%b arready=%b, want %b/1/0000", grant, s_arvalid, arr, ev); end
        end
        s_arready = 1'b1; #1;
        checks++;
        if (arr !== ev) begin errors++; $display("FAIL rr_arready: got %b want %b", arr, ev); end
        @(negedge clk);
        s_arready = 1'b0;
        if (!keep) arv[w] = 1'b0;
        arv  = arv | late;
        beat = 0;
        cyc  = 0;
        d = $urandom; rs = 2'($urandom); id = 4'($urandom);
        while (beat < nb && cyc < 64) begin
            s_rvalid = 1'b1; s_rdata = d; s_rresp = rs; s_rid = id;
            s_rlast  = (beat == nb - 1);
            rrdy     = 4'($urandom);
            rrdy[w]  = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            e_rd = '0; e_rd[w*32 +: 32] = d;
            e_rr = '0; e_rr[w*2 +: 2]   = rs;
            e_id = '0; e_id[w*4 +: 4]   = id;
            e_l  = (beat == nb - 1) ? ev : 4'b0;
            checks++;
            if ({rv, rl, rdata, rresp, rid} !== {ev, e_l, e_rd, e_rr, e_id})
                begin errors++; $display("FAIL rr_beat%0d: rvalid=%b rlast=%b rdata=%h rid=%h, want %b/%b/%h/%h",
                                         beat, rv, rl, rdata, rid, ev, e_l, e_rd, e_id); end
            checks++;
            if (s_rready !== rrdy[w] || grant !== ev || busy !== 1'b1 || s_arvalid !== 1'b0 || arr !== 4'b0)
                begin errors++; $display("FAIL rr_data_ctl: s_rready=%b grant=%b busy=%b s_arvalid=%b arready=%b, want %b/%b/1/0/0000",
                                         s_rready, grant, busy, s_arvalid, arr, rrdy[w], ev); end
            hs = rrdy[w];
            @(negedge clk);
            cyc++;
            if (hs) begin
                beat++;
                d = $urandom; rs = 2'($urandom); id = 4'($urandom);
            end
            if (beat == abort_after) return;
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; rrdy = 4'b0;
        checks++;
        if (beat != nb) begin errors++; $display("FAIL rr_timeout: delivered %0d beats, want %0d", beat, nb); end
        ptr = (w + 1) % 4;
        #1;
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || rv !== 4'b0)
            begin errors++; $display("FAIL rr_done: grant=%b busy=%b rvalid=%b, want 0000/0/0000", grant, busy, rv); end
    endtask

    // Single-beat transaction on the fixed-priority instance.
    task automatic fx_serve(input logic [31:0] d);
        int w;
        logic [1:0]  ev;
        logic [63:0] e_rd;
        w  = f_arv[0] ? 0 : 1;
        ev = 2'(1 << w);
        #1;
        checks++;
        if (f_grant !== 2'b0 || f_busy !== 1'b0 || f_s_arvalid !== 1'b0)
            begin errors++; $display("FAIL fx_idle: grant=%b busy=%b s_arvalid=%b, want 00/0/0", f_grant, f_busy, f_s_arvalid); end
        @(negedge clk); #1;
        checks++;
        if (f_grant !== ev || f_s_arvalid !== 1'b1 || f_s_araddr !== f_araddr[w*32 +: 32] || f_s_arlen !== 8'd0)
            begin errors++; $display("FAIL fx_addr: grant=%b s_arvalid=%b addr=%h, want %b/1/%h",
                                     f_grant, f_s_arvalid, f_s_araddr, ev, f_araddr[w*32 +: 32]); end
        f_s_arready = 1'b1; #1;
        checks++;
        if (f_arr !== ev) begin errors++; $display("FAIL fx_arready: got %b want %b", f_arr, ev); end
        @(negedge clk);
        f_s_arready = 1'b0; f_arv[w] = 1'b0;
        f_s_rvalid = 1'b1; f_s_rdata = d; f_s_rlast = 1'b1; f_s_rresp = AXI_RESP_OKAY; f_rrdy = 2'b11;
        #1;
        e_rd = '0; e_rd[w*32 +: 32] = d;
        checks++;
        if (f_rv !== ev || f_rl !== ev || f_rdata !== e_rd || f_s_rready !== 1'b1)
            begin errors++; $display("FAIL fx_beat: rvalid=%b rlast=%b rdata=%h s_rready=%b, want %b/%b/%h/1",
                                     f_rv, f_rl, f_rdata, f_s_rready, ev, ev, e_rd); end
        @(negedge clk);
        f_s_rvalid = 1'b0; f_s_rlast = 1'b0; f_rrdy = 2'b0;
        #1;
        checks++;
        if (f_grant !== 2'b0 || f_busy !== 1'b0 || f_rv !== 2'b0)
            begin errors++; $display("FAIL fx_done: grant=%b busy=%b rvalid=%b, want 00/0/00", f_grant, f_busy, f_rv); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        arv = 4'b1111; f_arv = 2'b11; rrdy = 4'b1111; s_rvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || s_arvalid !== 1'b0 || s_rready !== 1'b0 ||
            rv !== 4'b0 || arr !== 4'b0 || f_grant !== 2'b0 || f_busy !== 1'b0)
            begin errors++; $display("FAIL reset_state: grant=%b busy=%b s_arvalid=%b s_rready=%b rvalid=%b f_grant=%b, want all 0",
                                     grant, busy, s_arvalid, s_rready, rv, f_grant); end
        arv = 4'b0; f_arv = 2'b0; rrdy = 4'b0; s_rvalid = 1'b0;
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || f_busy !== 1'b0)
            begin errors++; $display("FAIL reset_idle: grant=%b busy=%b f_busy=%b, want 0", grant, busy, f_busy); end
        @(negedge clk);
        ptr = 0;
    endtask

    task automatic test_fixed();
        f_araddr[31:0] = 32'h8000_0000; f_arlen[7:0] = 8'd0; f_arv[0] = 1'b1;
        fx_serve(32'hDEAD_BEEF);
        f_araddr = {$urandom, $urandom}; f_arlen = 16'd0; f_arv = 2'b11;
        fx_serve($urandom);
        fx_serve($urandom);
    endtask

    task automatic test_rr_all_four();
        for (int m = 0; m < 4; m++) set_fields(m, $urandom, 8'd0);
        arv = 4'b1111;
        for (int t = 0; t < 5; t++) rr_serve(1'b0, 1'b1, 4'b0, -1);
        arv = 4'b0;
    endtask

    task automatic test_burst_toggle();
        set_fields(1, $urandom, 8'd3);
        arv[1] = 1'b1;
        rr_serve(1'b1, 1'b0, 4'b0, -1);
    endtask

    task automatic test_late_request();
        set_fields(1, $urandom, 8'd1);
        set_fields(0, $urandom, 8'd0);
        set_fields(2, $urandom, 8'd0);
        arv = 4'b0010;
        rr_serve(1'b0, 1'b0, 4'b0101, -1);
        rr_serve(1'b0, 1'b0, 4'b0, -1);
        rr_serve(1'b0, 1'b0, 4'b0, -1);
    endtask

    task automatic test_reset_mid_burst();
        set_fields(2, $urandom, 8'd3);
        arv = 4'b0100;
        rr_serve(1'b0, 1'b0, 4'b0, 2);
        s_rvalid = 1'b1; s_rlast = 1'b0; rrdy = 4'b1111;
        reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || arr !== 4'b0 || rv !== 4'b0 || rl !== 4'b0 ||
            rdata !== 128'b0 || rresp !== 8'b0 || rid !== 16'b0 || s_arvalid !== 1'b0 || s_rready !== 1'b0)
            begin errors++; $display("FAIL reset_mid: grant=%b busy=%b rvalid=%b rdata=%h s_rready=%b, want all 0",
                                     grant, busy, rv, rdata, s_rready); end
        reset = 1'b0; s_rvalid = 1'b0; rrdy = 4'b0;
        ptr = 0;
        set_fields(1, $urandom, 8'd0);
        set_fields(3, $urandom, 8'd1);
        arv = 4'b1010;
        rr_serve(1'b0, 1'b0, 4'b0, -1);
    endtask

    task automatic test_random();
        logic [3:0] add;
        for (int it = 0; it < 20; it++) begin
            add = 4'($urandom);
            if (arv == 4'b0 && add == 4'b0) add = 4'b0001 << $urandom_range(0, 3);
            for (int m = 0; m < 4; m++) begin
                if (add[m] && !arv[m]) begin
                    set_fields(m, $urandom, 8'($urandom_range(0, 3)));
                    arv[m] = 1'b1;
                end
            end
            rr_serve(1'($urandom), 1'b0, 4'b0, -1);
        end
        arv = 4'b0;
    endtask

    initial begin
        reset = 1'b1;
        arv = '0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; rrdy = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rid = '0;
        f_arv = '0; f_araddr = '0; f_arid = '0; f_arlen = '0; f_arsize = '0; f_arburst = '0; f_rrdy = '0;
        f_s_arready = 1'b0; f_s_rvalid = 1'b0; f_s_rdata = '0; f_s_rresp = '0; f_s_rlast = 1'b0; f_s_rid = '0;
        @(negedge clk);
        test_reset();
        test_fixed();
        test_rr_all_four();
        test_burst_toggle();
        test_late_request();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
